// File: rtl/hba_gpio_n.sv
// rtl/hba_gpio_n.sv - HBA bus GPIO peripheral with per-pin debounce and edge interrupts
module hba_gpio_n #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_PINS          = 8
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  output logic                  hba_xferack_slave,
  output logic                  slave_interrupt,
  output logic [NUM_PINS-1:0]   gpio_out_en,
  output logic [NUM_PINS-1:0]   gpio_out_sig,
  input  logic [NUM_PINS-1:0]   gpio_in_sig
);

  localparam logic [REG_ADDR_WIDTH-1:0] R_DIR  = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] R_PINS = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] R_IEN  = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] R_RISE = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] R_FALL = REG_ADDR_WIDTH'(4);
  localparam logic [REG_ADDR_WIDTH-1:0] R_STAT = REG_ADDR_WIDTH'(5);
  localparam logic [REG_ADDR_WIDTH-1:0] R_DEB  = REG_ADDR_WIDTH'(6);

  logic [NUM_PINS-1:0]   dir, latch, intr_en, rise_en, fall_en, intr_stat;
  logic [DBUS_WIDTH-1:0] debounce;
  logic [NUM_PINS-1:0]   sync1, sync2, deb, prev_deb;
  logic [DBUS_WIDTH-1:0] cnt [NUM_PINS];

  logic [REG_ADDR_WIDTH-1:0]    reg_sel;
  logic [PERIPH_ADDR_WIDTH-1:0] periph_sel;
  logic                         access, wr, rd;
  logic [DBUS_WIDTH-1:0]        rdata;
  logic [NUM_PINS-1:0]          wdata, stat_clr, stat_set, stat_next;

  assign reg_sel    = hba_abus[REG_ADDR_WIDTH-1:0];
  assign periph_sel = hba_abus[ADDR_WIDTH-1 -: PERIPH_ADDR_WIDTH];
  // An acked cycle never starts a second access, so back-to-back selects alternate.
  assign access     = hba_select && (periph_sel == PERIPH_ADDR_WIDTH'(PERIPH_ADDR)) && !hba_xferack_slave;
  assign wr         = access && !hba_rnw;
  assign rd         = access && hba_rnw;
  assign wdata      = hba_dbus[NUM_PINS-1:0];

  assign gpio_out_en  = dir;
  assign gpio_out_sig = latch;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      R_DIR:   rdata[NUM_PINS-1:0] = dir;
      R_PINS:  rdata[NUM_PINS-1:0] = (latch & dir) | (deb & ~dir);
      R_IEN:   rdata[NUM_PINS-1:0] = intr_en;
      R_RISE:  rdata[NUM_PINS-1:0] = rise_en;
      R_FALL:  rdata[NUM_PINS-1:0] = fall_en;
      R_STAT:  rdata[NUM_PINS-1:0] = intr_stat;
      R_DEB:   rdata = debounce;
      default: rdata = '0;
    endcase
  end

  // A new edge wins over a simultaneous write-1-to-clear.
  always_comb begin
    stat_clr  = (wr && reg_sel == R_STAT) ? wdata : '0;
    stat_set  = ~dir & intr_en & ((deb & ~prev_deb & rise_en) | (~deb & prev_deb & fall_en));
    stat_next = (intr_stat & ~stat_clr) | stat_set;
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      hba_xferack_slave <= 1'b0;
      hba_dbus_slave    <= '0;
      slave_interrupt   <= 1'b0;
      dir               <= '0;
      latch             <= '0;
      intr_en           <= '0;
      rise_en           <= '0;
      fall_en           <= '0;
      intr_stat         <= '0;
      debounce          <= '0;
    end else begin
      hba_xferack_slave <= access;
      hba_dbus_slave    <= rd ? rdata : '0;
      intr_stat         <= stat_next;
      slave_interrupt   <= |(intr_stat & intr_en);
      if (wr) begin
        case (reg_sel)
          R_DIR:   dir      <= wdata;
          R_PINS:  latch    <= wdata;
          R_IEN:   intr_en  <= wdata;
          R_RISE:  rise_en  <= wdata;
          R_FALL:  fall_en  <= wdata;
          R_DEB:   debounce <= hba_dbus;
          default: ;
        endcase
      end
    end
  end

  // Per-pin debounce: deb adopts sync once it has differed for DEBOUNCE+1 cycles.
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      prev_deb <= '0;
      for (int i = 0; i < NUM_PINS; i++) cnt[i] <= '0;
    end else begin
      sync1    <= gpio_in_sig;
      sync2    <= sync1;
      prev_deb <= deb;
      for (int i = 0; i < NUM_PINS; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == debounce) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else if (cnt[i] != {DBUS_WIDTH{1'b1}}) begin
          cnt[i] <= cnt[i] + DBUS_WIDTH'(1);
        end
      end
    end
  end

endmodule
